// File: rtl/decode_stage.sv
// Decode stage: captures an instruction word and its npc on enable_decode and
// registers the execute/writeback/memory control fields decoded from it.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        valid,
  output logic        illegal,
  output logic [3:0]  illegal_count
);

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
    OP_JSR  = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
    OP_RTI  = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
    OP_JMP  = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
  } opcode_e;

  opcode_e     opcode;
  logic [1:0]  alu_ctl, pcsel1, dec_w;
  logic        pcsel2, op2sel, dec_mem, dec_ill;

  logic [15:0] ir_q, ir_d, npc_q, npc_d;
  logic [5:0]  e_ctl_q, e_ctl_d;
  logic [1:0]  w_ctl_q, w_ctl_d;
  logic        mem_ctl_q, mem_ctl_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  ill_cnt_q, ill_cnt_d;

  assign opcode = opcode_e'(dout[15:12]);

  // Decode looks only at the incoming word, never at the held IR.
  always_comb begin
    alu_ctl = 2'b00;
    pcsel1  = 2'b00;
    pcsel2  = 1'b0;
    op2sel  = 1'b0;
    dec_w   = 2'b00;
    dec_mem = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OP_ADD:  op2sel = ~dout[5];
      OP_AND:  begin alu_ctl = 2'b01; op2sel = ~dout[5]; end
      OP_NOT:  begin alu_ctl = 2'b10; op2sel = 1'b1; end
      OP_BR,
      OP_ST:   begin pcsel1 = 2'b01; pcsel2 = 1'b1; end
      OP_LD:   begin pcsel1 = 2'b01; pcsel2 = 1'b1; dec_w = 2'b01; end
      OP_LDI:  begin pcsel1 = 2'b01; pcsel2 = 1'b1; dec_w = 2'b01; dec_mem = 1'b1; end
      OP_STI:  begin pcsel1 = 2'b01; pcsel2 = 1'b1; dec_mem = 1'b1; end
      OP_LEA:  begin pcsel1 = 2'b01; pcsel2 = 1'b1; dec_w = 2'b10; end
      OP_LDR:  begin pcsel1 = 2'b10; dec_w = 2'b01; end
      OP_STR:  pcsel1 = 2'b10;
      OP_JMP:  pcsel1 = 2'b11;
      OP_JSR,
      OP_RTI,
      OP_RES,
      OP_TRAP: dec_ill = 1'b1;
      default: dec_ill = 1'b0;
    endcase
  end

  always_comb begin
    ir_d      = ir_q;
    npc_d     = npc_q;
    e_ctl_d   = e_ctl_q;
    w_ctl_d   = w_ctl_q;
    mem_ctl_d = mem_ctl_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    ill_cnt_d = ill_cnt_q;
    if (enable_decode) begin
      ir_d      = dout;
      npc_d     = npc_in;
      e_ctl_d   = {alu_ctl, pcsel1, pcsel2, op2sel};
      w_ctl_d   = dec_w;
      mem_ctl_d = dec_mem;
      illegal_d = dec_ill;
      valid_d   = 1'b1;
      if (dec_ill && (ill_cnt_q != '1))
        ill_cnt_d = ill_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_q      <= '0;
      npc_q     <= '0;
      e_ctl_q   <= '0;
      w_ctl_q   <= '0;
      mem_ctl_q <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      ir_q      <= ir_d;
      npc_q     <= npc_d;
      e_ctl_q   <= e_ctl_d;
      w_ctl_q   <= w_ctl_d;
      mem_ctl_q <= mem_ctl_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign IR            = ir_q;
  assign npc_out       = npc_q;
  assign E_Control     = e_ctl_q;
  assign W_Control     = w_ctl_q;
  assign Mem_Control   = mem_ctl_q;
  assign valid         = valid_q;
  assign illegal       = illegal_q;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// stimulus compared against a behavioural reference model.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable_decode = 1'b0;
  logic [15:0] dout = '0;
  logic [15:0] npc_in = '0;
  logic [15:0] IR, npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control, valid, illegal;
  logic [3:0]  illegal_count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // reference model state
  logic [15:0] m_ir, m_npc;
  logic [5:0]  m_e;
  logic [1:0]  m_w;
  logic        m_mem, m_valid, m_ill;
  int          m_cnt;

  decode_stage dut (
    .clock(clock), .reset(reset), .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in), .IR(IR), .npc_out(npc_out),
    .E_Control(E_Control), .W_Control(W_Control), .Mem_Control(Mem_Control),
    .valid(valid), .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ir = '0; m_npc = '0; m_e = '0; m_w = '0;
    m_mem = 0; m_valid = 0; m_ill = 0; m_cnt = 0;
  endfunction

  // Field values straight from the opcode tables.
  function automatic void model_capture(input logic [15:0] d, input logic [15:0] n);
    int op;
    int alu, ps1, ps2, op2, w, mem, ill;
    op  = int'(d[15:12]);
    ill = (op == 4 || op == 8 || op == 13 || op == 15);
    alu = (op == 5) ? 1 : (op == 9) ? 2 : 0;
    ps2 = (op == 0 || op == 2 || op == 10 || op == 3 || op == 11 || op == 14);
    ps1 = ps2 ? 1 : (op == 6 || op == 7) ? 2 : (op == 12) ? 3 : 0;
    op2 = (op == 9) || ((op == 1 || op == 5) && d[5] == 1'b0);
    w   = (op == 2 || op == 6 || op == 10) ? 1 : (op == 14) ? 2 : 0;
    mem = (op == 10 || op == 11);
    m_ir = d; m_npc = n; m_valid = 1; m_ill = logic'(ill);
    m_e  = 6'(alu * 16 + ps1 * 4 + ps2 * 2 + op2);
    m_w  = 2'(w);
    m_mem = logic'(mem);
    if (ill != 0 && m_cnt < 15) m_cnt++;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".IR"},   IR, m_ir);
    check({tag, ".npc"},  npc_out, m_npc);
    check({tag, ".E"},    16'(E_Control), 16'(m_e));
    check({tag, ".W"},    16'(W_Control), 16'(m_w));
    check({tag, ".Mem"},  16'(Mem_Control), 16'(m_mem));
    check({tag, ".valid"}, 16'(valid), 16'(m_valid));
    check({tag, ".ill"},  16'(illegal), 16'(m_ill));
    check({tag, ".cnt"},  16'(illegal_count), 16'(m_cnt));
  endtask

  // Called at a negedge; drives inputs, lets one rising edge pass, checks, returns at negedge.
  task automatic step(input string tag, input logic en, input logic [15:0] d, input logic [15:0] n);
    enable_decode = en; dout = d; npc_in = n;
    @(posedge clock);
    #1;
    if (en) model_capture(d, n);
    compare_all(tag);
    @(negedge clock);
  endtask

  // Asynchronous pulse mid-cycle; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    #1 compare_all("por");
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    step("idle_after_rst", 1'b0, 16'h1234, 16'h5678);

    step("add", 1'b1, 16'h12A5, 16'h3001);
    check("add.E_lit", 16'(E_Control), 16'h0000);
    check("add.valid_lit", 16'(valid), 16'h0001);
    step("ldr", 1'b1, 16'h6702, 16'h3002);
    check("ldr.E_lit", 16'(E_Control), 16'h0008);
    step("ldi", 1'b1, 16'hA003, 16'h3003);
    check("ldi.E_lit", 16'(E_Control), 16'h0006);
    check("ldi.Mem_lit", 16'(Mem_Control), 16'h0001);
    step("not", 1'b1, 16'h927F, 16'h3004);
    for (int unsigned i = 0; i < 3; i++) step("hold", 1'b0, 16'h0E05, 16'h4000);
    check("hold.E_lit", 16'(E_Control), 16'h0021);
    check("hold.IR_lit", IR, 16'h927F);

    for (int unsigned i = 0; i < 17; i++) step("trap", 1'b1, 16'hF025, 16'(16'h3100 + i));
    check("trap.cnt_lit", 16'(illegal_count), 16'h000F);
    check("trap.E_lit", 16'(E_Control), 16'h0000);

    step("jmp", 1'b1, 16'hC1C0, 16'h3200);
    check("jmp.E_lit", 16'(E_Control), 16'h000C);
    async_reset("mid_rst");
    step("no_cap_after_rst", 1'b0, 16'hC1C0, 16'h3201);

    for (int unsigned i = 0; i < 600; i++) begin
      logic        en;
      logic [15:0] d;
      en = ($urandom_range(0, 3) != 0);
      d  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d[15:12] = 4'hF;
      if (i % 150 == 149) async_reset("rnd_rst");
      else step("rnd", en, d, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable_decode  input  1  capture strobe from the controller.
- dout  input  16  instruction word from instruction memory (fetched at pc).
- npc_in  input  16  pc+1 from the fetch stage.
- IR  output  16  registered instruction.
- npc_out  output  16  registered npc_in.
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  output  2  writeback source select.
- Mem_Control  output  1  1 = indirect memory access.
- valid  output  1  IR holds a captured instruction.
- illegal  output  1  captured opcode is unsupported.
- illegal_count  output  4  saturating count of illegal captures.

Function
REQ-003 On a rising clock with enable_decode=1, IR, npc_out, E_Control, W_Control, Mem_Control and illegal SHALL update from dout/npc_in with latency of one cycle.
REQ-004 With enable_decode=0, every output SHALL hold its value.
REQ-005 valid SHALL go 1 on the first capture after reset and stay 1 until reset.
REQ-006 alu_control SHALL be: ADD(0001)=00, AND(0101)=01, NOT(1001)=10, all other opcodes=00.
REQ-007 pcselect1 SHALL be:
- 01 (offset9) for BR 0000, LD 0010, LDI 1010, ST 0011, STI 1011, LEA 1110.
- 10 (offset6) for LDR 0110, STR 0111.
- 11 (zero) for JMP 1100.
- 00 otherwise.
REQ-008 pcselect2 SHALL be 1 (npc base) for BR, LD, LDI, ST, STI and LEA, and 0 otherwise.
REQ-009 op2select SHALL be:
- 1 for NOT.
- 1 for ADD/AND with dout[5]=0.
- 0 for ADD/AND with dout[5]=1.
- 0 for all other opcodes.
REQ-010 W_Control SHALL be:
- 00 for ADD/AND/NOT.
- 01 for LD, LDR, LDI.
- 10 for LEA.
- 00 otherwise.
REQ-011 Mem_Control SHALL be 1 for LDI and STI, and 0 otherwise.
REQ-012 illegal SHALL be 1 for opcodes JSR 0100, RTI 1000, reserved 1101 and TRAP 1111; for these, E_Control, W_Control and Mem_Control SHALL all be 0.
REQ-013 illegal_count SHALL increment on each capture with illegal decode, and SHALL saturate at 4'hF with no wrap.
REQ-014 Decode SHALL be a pure function of dout at the capture edge; no control output SHALL depend on the previously held IR.
REQ-015 enable_decode held high across consecutive cycles SHALL capture one new instruction per cycle, with no bubble inserted.

Reset
REQ-016 When reset=0, regardless of clock, the block SHALL immediately drive:
- IR=16'h0000, npc_out=16'h0000.
- E_Control=6'h00, W_Control=2'b00, Mem_Control=0.
- valid=0, illegal=0, illegal_count=4'h0.
REQ-017 Reset asserted mid-stream SHALL discard the held instruction.
REQ-018 Reset deasserted SHALL cause no capture until the first rising edge with enable_decode=1.

Verification
REQ-019 Reset, then dout=16'h12A5 (ADD R1,R2,#5), npc_in=16'h3001, enable_decode=1 -> next cycle IR=12A5, npc_out=3001, E_Control=6'h00, W_Control=00, Mem_Control=0, valid=1.
REQ-020 dout=16'h6702 (LDR) captured -> E_Control=6'h08, W_Control=01, Mem_Control=0; then dout=16'hA003 (LDI) captured -> E_Control=6'h06, W_Control=01, Mem_Control=1.
REQ-021 dout=16'h927F (NOT) captured, then enable_decode=0 for 3 cycles while dout changes to 16'h0E05 -> E_Control stays 6'h21 and IR stays 927F.
REQ-022 Seventeen consecutive captures of 16'hF025 (TRAP) -> illegal=1, E_Control=0, illegal_count reaches 4'hF and holds there.
REQ-023 Reset pulsed low asynchronously mid-clock after a capture of 16'hC1C0 (JMP, E_Control=6'h0C) -> all outputs become 0 before the next clock edge; valid=0.
